// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the general-purpose register file.
// Picks one of two writeback requesters (EXU = req0, LSU = req1) each cycle
// using a round-robin pointer, and registers the winner onto the single write port.
// It also keeps the per-register busy scoreboard that drives the issue-stage hazard flag.
module regfile_wb_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int REG_NUM     = 32,
    parameter int REG_NUM_BIT = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rsv_valid,
    input  logic [REG_NUM_BIT-1:0] rsv_rd,
    input  logic [REG_NUM_BIT-1:0] chk_rs1,
    input  logic [REG_NUM_BIT-1:0] chk_rs2,
    input  logic [REG_NUM_BIT-1:0] chk_rd,
    output logic                   hazard,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [REG_NUM_BIT-1:0] req0_rd,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [REG_NUM_BIT-1:0] req1_rd,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    output logic                   rf_wen,
    output logic [REG_NUM_BIT-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0]  rf_wdata,
    output logic [REG_NUM-1:0]     busy
);

    // r_ptr = 0 favours req0 on contention, r_ptr = 1 favours req1
    logic                   r_ptr;
    logic                   r_wen;
    logic [REG_NUM_BIT-1:0] r_waddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [REG_NUM-1:0]     r_busy;

    logic                   w_gnt0;
    logic                   w_gnt1;
    logic                   w_both;
    logic                   w_hs;
    logic [REG_NUM_BIT-1:0] w_rd;
    logic [DATA_WIDTH-1:0]  w_data;
    logic                   w_commit;
    logic [REG_NUM-1:0]     w_busy_nxt;

    // Combinational round-robin grant; a lone requester always wins
    always_comb begin
        w_both = req0_valid & req1_valid;
        w_gnt0 = req0_valid & (~req1_valid | ~r_ptr);
        w_gnt1 = req1_valid & (~req0_valid |  r_ptr);
        w_hs   = w_gnt0 | w_gnt1;
        w_rd   = w_gnt0 ? req0_rd   : req1_rd;
        w_data = w_gnt0 ? req0_data : req1_data;
        // Writes to x0 complete the handshake but never reach the register file
        w_commit = w_hs & (w_rd != '0);
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Scoreboard next state: the commit clears first, so a same-edge reservation wins
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen) begin
            w_busy_nxt[r_waddr] = 1'b0;
        end
        if (rsv_valid && (rsv_rd != '0)) begin
            w_busy_nxt[rsv_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Register the granted write and advance the pointer after contention
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_both) begin
                r_ptr <= w_gnt0;
            end
            r_wen <= w_commit;
            if (w_commit) begin
                r_waddr <= w_rd;
                r_wdata <= w_data;
            end
        end
    end

    // Busy scoreboard: set by reservation, cleared by write commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // No bypass: a register being written this cycle still reads as busy
    always_comb begin
        hazard = ((chk_rs1 != '0) & r_busy[chk_rs1]) |
                 ((chk_rs2 != '0) & r_busy[chk_rs2]) |
                 ((chk_rd  != '0) & r_busy[chk_rd]);
    end

    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign busy     = r_busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: a transaction-level model checked at every
// negedge, plus directed scenarios that carry hand-computed literal expectations.
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst_n;
    logic        rsv_valid;
    logic [4:0]  rsv_rd;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic        req0_valid;
    logic        req0_ready;
    logic [4:0]  req0_rd;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic        req1_ready;
    logic [4:0]  req1_rd;
    logic [31:0] req1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy;

    int n_vec = 0;
    int n_err = 0;
    bit done  = 0;

    regfile_wb_scheduler #(.DATA_WIDTH(32), .REG_NUM(32), .REG_NUM_BIT(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_valid  (rsv_valid),
        .rsv_rd     (rsv_rd),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .hazard     (hazard),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_rd    (req0_rd),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_rd    (req1_rd),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending write seen by the register file, set of outstanding destinations,
    // and which requester currently has the right of way on contention.
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_pend [32];
    int          m_fav;

    function automatic bit m_busy(input logic [4:0] r);
        return (r != 0) && m_pend[r];
    endfunction

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    initial begin
        m_wen = 0; m_waddr = '0; m_wdata = '0; m_fav = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    end

    // Mid-cycle compare, then advance the model to what the coming posedge must produce
    always @(negedge clk) begin
        int g;
        int rd;
        if (!done) begin
            if (!rst_n) begin
                m_wen = 0; m_waddr = '0; m_wdata = '0; m_fav = 0;
                for (int i = 0; i < 32; i++) m_pend[i] = 0;
                chk("rst_wen",   rf_wen,   1'b0);
                chk("rst_waddr", rf_waddr, 5'd0);
                chk("rst_wdata", rf_wdata, 32'd0);
                chk("rst_busy",  busy,     32'd0);
            end else begin
                chk("m_wen", rf_wen, m_wen);
                if (m_wen) begin
                    chk("m_waddr", rf_waddr, m_waddr);
                    chk("m_wdata", rf_wdata, m_wdata);
                end
                chk("m_busy", busy, m_busy_vec());
                chk("m_hazard", hazard, m_busy(chk_rs1) | m_busy(chk_rs2) | m_busy(chk_rd));

                if (req0_valid && req1_valid) g = m_fav;
                else if (req0_valid)          g = 0;
                else if (req1_valid)          g = 1;
                else                          g = -1;
                chk("m_ready0", req0_ready, g == 0);
                chk("m_ready1", req1_ready, g == 1);

                if (m_wen) m_pend[m_waddr] = 0;
                if (rsv_valid && rsv_rd != 0) m_pend[rsv_rd] = 1;
                if (req0_valid && req1_valid) m_fav = 1 - g;
                m_wen = 0;
                if (g >= 0) begin
                    rd = (g == 0) ? int'(req0_rd) : int'(req1_rd);
                    if (rd != 0) begin
                        m_wen   = 1;
                        m_waddr = (g == 0) ? req0_rd : req1_rd;
                        m_wdata = (g == 0) ? req0_data : req1_data;
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rsv_valid = 0; rsv_rd = '0;
        req0_valid = 0; req0_rd = '0; req0_data = '0;
        req1_valid = 0; req1_rd = '0; req1_data = '0;
    endtask

    initial begin
        int  exp_seq [4];
        bit  g0;
        rst_n = 0;
        chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
        step();

        // Single request from EXU
        req0_valid = 1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF;
        #1;
        chk("a_ready0", req0_ready, 1'b1);
        step();
        req0_valid = 0;
        chk("a_wen", rf_wen, 1'b1);
        chk("a_waddr", rf_waddr, 5'd5);
        chk("a_wdata", rf_wdata, 32'hDEADBEEF);
        step();
        chk("a_wen_off", rf_wen, 1'b0);
        chk("a_waddr_hold", rf_waddr, 5'd5);

        // Contention: grants must alternate starting with req0
        exp_seq = '{0, 1, 0, 1};
        req0_valid = 1; req0_rd = 5'd1; req0_data = 32'h11;
        req1_valid = 1; req1_rd = 5'd2; req1_data = 32'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            g0 = req0_ready;
            chk("b_grant0", g0, exp_seq[k] == 0);
            step();
            if (g0) req0_data = req0_data + 32'h100;
            else    req1_data = req1_data + 32'h100;
            chk("b_wen", rf_wen, 1'b1);
            chk("b_waddr", rf_waddr, (exp_seq[k] == 0) ? 5'd1 : 5'd2);
        end
        req0_valid = 0; req1_valid = 0;
        step();
        chk("b_wen_off", rf_wen, 1'b0);

        // Scoreboard: reserve x7, hazard until the write to x7 commits
        rsv_valid = 1; rsv_rd = 5'd7;
        step();
        rsv_valid = 0;
        chk_rs1 = 5'd7;
        #1;
        chk("c_busy", busy, 32'h0000_0080);
        chk("c_hazard", hazard, 1'b1);
        step();
        step();
        chk("c_hazard_hold", hazard, 1'b1);
        req1_valid = 1; req1_rd = 5'd7; req1_data = 32'h77;
        #1;
        chk("c_ready1", req1_ready, 1'b1);
        step();
        req1_valid = 0;
        chk("c_wen7", rf_wen, 1'b1);
        chk("c_hazard_nobypass", hazard, 1'b1);
        step();
        chk("c_hazard_clear", hazard, 1'b0);
        chk("c_busy_clear", busy, 32'd0);
        chk_rs1 = '0;

        // Set/clear collision on x3: set wins
        rsv_valid = 1; rsv_rd = 5'd3;
        step();
        rsv_valid = 0;
        req0_valid = 1; req0_rd = 5'd3; req0_data = 32'h33;
        step();
        req0_valid = 0;
        rsv_valid = 1; rsv_rd = 5'd3;
        chk("d_wen3", rf_wen, 1'b1);
        step();
        rsv_valid = 0;
        chk("d_busy3_kept", busy[3], 1'b1);
        chk_rd = 5'd3;
        #1;
        chk("d_hazard_waw", hazard, 1'b1);
        req1_valid = 1; req1_rd = 5'd3; req1_data = 32'h3333;
        step();
        req1_valid = 0;
        step();
        chk("d_busy3_clear", busy[3], 1'b0);
        chk_rd = '0;

        // x0: reservation ignored, request accepted but never written
        rsv_valid = 1; rsv_rd = 5'd0;
        req0_valid = 1; req0_rd = 5'd0; req0_data = 32'hFF;
        #1;
        chk("e_ready0", req0_ready, 1'b1);
        step();
        idle_inputs();
        chk("e_wen", rf_wen, 1'b0);
        chk("e_busy", busy, 32'd0);
        chk_rs1 = 5'd0;
        #1;
        chk("e_hazard", hazard, 1'b0);

        // Async reset during an active write; pointer left favouring req1 first
        step();
        req0_valid = 1; req0_rd = 5'd4; req0_data = 32'h44;
        req1_valid = 1; req1_rd = 5'd6; req1_data = 32'h66;
        rsv_valid = 1; rsv_rd = 5'd9;
        step();
        idle_inputs();
        req1_valid = 1; req1_rd = 5'd9; req1_data = 32'h99;
        step();
        idle_inputs();
        chk("f_wen_pre", rf_wen, 1'b1);
        #1;
        rst_n = 0;
        #1;
        chk("f_wen", rf_wen, 1'b0);
        chk("f_waddr", rf_waddr, 5'd0);
        chk("f_wdata", rf_wdata, 32'd0);
        chk("f_busy", busy, 32'd0);
        step();
        step();
        rst_n = 1;
        step();
        req0_valid = 1; req0_rd = 5'd10; req0_data = 32'hA0;
        req1_valid = 1; req1_rd = 5'd11; req1_data = 32'hB0;
        #1;
        chk("f_first_ready0", req0_ready, 1'b1);
        chk("f_first_ready1", req1_ready, 1'b0);
        step();
        idle_inputs();
        step();
        step();

        done = 1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Sequences the single write port of the general-purpose register file: DATA_WIDTH x REG_NUM, x0 hardwired to zero, write on posedge clk when wen, combinational reads.
- Arbitrates round-robin between two writeback requesters, EXU (req0) and LSU (req1), using valid/ready handshakes, and drives wen/waddr/wdata from registers.
- Keeps a per-register busy scoreboard, reserved by the issue stage and released on write commit, and produces a combinational hazard flag for issue stall.

Parameters:
- DATA_WIDTH, 32, register data width
- REG_NUM, 32, number of architectural registers
- REG_NUM_BIT, 5, register index width

Ports:
- clk  in  1  clock; all state on posedge
- rst_n  in  1  asynchronous reset, active-low
- rsv_valid  in  1  issue stage reserves rsv_rd this cycle
- rsv_rd  in  REG_NUM_BIT  destination register being reserved
- chk_rs1  in  REG_NUM_BIT  issue-stage source 1 to check
- chk_rs2  in  REG_NUM_BIT  issue-stage source 2 to check
- chk_rd  in  REG_NUM_BIT  issue-stage destination to check (WAW)
- hazard  out  1  combinational: any checked register is busy
- req0_valid  in  1  EXU writeback request
- req0_ready  out  1  EXU request accepted this cycle
- req0_rd  in  REG_NUM_BIT  EXU destination
- req0_data  in  DATA_WIDTH  EXU result
- req1_valid  in  1  LSU writeback request
- req1_ready  out  1  LSU request accepted this cycle
- req1_rd  in  REG_NUM_BIT  LSU destination
- req1_data  in  DATA_WIDTH  LSU load data
- rf_wen  out  1  register file write enable (registered)
- rf_waddr  out  REG_NUM_BIT  register file write address (registered)
- rf_wdata  out  DATA_WIDTH  register file write data (registered)
- busy  out  REG_NUM  scoreboard bitmap; bit 0 always 0

Behaviour:
- Reset (rst_n low, asynchronous): rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0, priority pointer=0 (req0 favoured). Outputs hold reset values while rst_n is low. Any in-flight write is dropped.
- Arbitration is combinational within the cycle:
  - only one valid: that requester is granted;
  - both valid: the pointer's requester is granted.
- readyN=1 only for the granted requester; the handshake completes when validN and readyN are both 1 at posedge.
- Pointer: after a cycle where both were valid, it moves to the non-granted requester. With a single requester it is unchanged.
- Requesters hold valid, rd and data stable until accepted; a non-granted request waits. Starvation bound: 1 cycle.
- Latency: a handshake at edge N gives rf_wen=1 with the latched rd/data during cycle N+1; the register file captures at edge N+1. Throughput is 1 write per cycle.
- rf_wen deasserts the cycle after an edge with no handshake; rf_waddr/rf_wdata hold their last values.
- rd==0 requests: the handshake completes, rf_wen stays 0, busy is unaffected.
- Scoreboard:
  - rsv_valid with rsv_rd!=0 sets busy[rsv_rd] at posedge; rsv_rd==0 is ignored.
  - rf_wen=1 at posedge clears busy[rf_waddr] at that edge, the same edge the register file is written.
  - Same register set and cleared on one edge: set wins.
  - Reserving an already-busy register leaves it busy. Upstream must not do this; chk_rd exists to prevent it.
- hazard = (chk_rs1!=0 & busy[chk_rs1]) | (chk_rs2!=0 & busy[chk_rs2]) | (chk_rd!=0 & busy[chk_rd]).
  - hazard is purely combinational from busy and the chk inputs. There is no bypass, so a register being written this cycle still reads as busy.
- busy[0] is constant 0.

Test Plan:
- Reset: drive rst_n low mid-write (rf_wen=1) -> rf_wen, rf_waddr, rf_wdata and busy go to 0 immediately, without a clock edge. After release, req0 wins the first contention.
- Single request: req0_valid=1, rd=5, data=0xDEADBEEF -> req0_ready=1 the same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_wen=0.
- Contention: both valid for 4 cycles (req0 rd=1/0x11, req1 rd=2/0x22, new data after each accept) -> grants alternate req0, req1, req0, req1; rf_wen is 1 on 4 consecutive cycles.
- Scoreboard: reserve rd=7, then chk_rs1=7 -> hazard=1 until the write to 7 commits. At the edge with rf_wen=1, rf_waddr=7, busy[7] clears and hazard drops in the next cycle.
- Set/clear collision: rsv_rd=3 on the same edge that rf_wen=1, rf_waddr=3 -> busy[3] remains 1.
- x0: reserve rd=0 and request rd=0 -> busy stays 0, ready=1, rf_wen stays 0; chk_rs1=0 -> hazard=0.
